// File: rtl/ethernet_rx.sv
// UDP/IPv4 receive engine: takes raw Ethernet frames from the MAC, checks the
// Ethernet/IPv4/UDP headers on the first beat against the local addresses,
// strips the 42 header bytes and realigns the payload to byte 0. Also supports
// a raw bypass path and a discard mode.
module ethernet_rx #(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned CONN_ID_WIDTH = 18
) (
    input  logic                    rx_axis_aclk,
    input  logic                    rx_axis_aresetn,

    input  logic                    rx_engine_bypass,
    input  logic                    rx_engine_enable,

    input  logic [31:0]             my_config_ipAddr,
    input  logic [47:0]             my_config_macAddr,
    input  logic [15:0]             my_config_udpPort,

    input  logic [DATA_WIDTH-1:0]   cmac_rx_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] cmac_rx_axis_tkeep,
    input  logic                    cmac_rx_axis_tvalid,
    input  logic                    cmac_rx_axis_tlast,
    output logic                    cmac_rx_axis_tready,

    output logic [DATA_WIDTH-1:0]   udp_rx_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] udp_rx_axis_tkeep,
    output logic                    udp_rx_axis_tvalid,
    output logic                    udp_rx_axis_tlast,
    input  logic                    udp_rx_axis_tready,

    output logic                    udp_rx_meta_valid,
    input  logic                    udp_rx_meta_ready,
    output logic [47:0]             udp_rx_meta_srcMac,
    output logic [31:0]             udp_rx_meta_srcIp,
    output logic [15:0]             udp_rx_meta_srcPort,
    output logic [15:0]             udp_rx_meta_length,

    output logic [31:0]             stat_accepted,
    output logic [31:0]             stat_dropped
);

    // Byte offsets below are fixed for a 64-byte beat.
    if (DATA_WIDTH != 512 || CONN_ID_WIDTH == 0) begin : g_param_check
        $error("ethernet_rx: only DATA_WIDTH = 512 is supported");
    end

    typedef enum logic [2:0] {StIdle, StFwd, StTail, StBypass, StDrop} state_e;

    state_e         state_q, state_d;
    logic [511:0]   out_data_q, out_data_d;
    logic [63:0]    out_keep_q, out_keep_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic [175:0]   hold_q, hold_d;
    logic [21:0]    hold_keep_q, hold_keep_d;
    logic           meta_valid_q, meta_valid_d;
    logic [47:0]    meta_mac_q, meta_mac_d;
    logic [31:0]    meta_ip_q, meta_ip_d;
    logic [15:0]    meta_port_q, meta_port_d;
    logic [15:0]    meta_len_q, meta_len_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    drop_q, drop_d;

    logic [7:0]     in_b [64];
    logic [47:0]    dst_mac;
    logic           hdr_ok;
    logic           out_free;
    logic           meta_free;
    logic           beat;
    logic           tail_empty;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Split the beat into wire-order bytes and evaluate the header checks.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            in_b[i] = cmac_rx_axis_tdata[8*i +: 8];
        end
        dst_mac = {in_b[0], in_b[1], in_b[2], in_b[3], in_b[4], in_b[5]};
        hdr_ok  = cmac_rx_axis_tkeep[41]
                & ((dst_mac == my_config_macAddr) || (dst_mac == 48'hFFFF_FFFF_FFFF))
                & (in_b[12] == 8'h08) & (in_b[13] == 8'h00)
                & (in_b[14] == 8'h45) & (in_b[23] == 8'h11)
                & ({in_b[30], in_b[31], in_b[32], in_b[33]} == my_config_ipAddr)
                & ({in_b[36], in_b[37]} == my_config_udpPort);
        tail_empty = (cmac_rx_axis_tkeep[63:42] == 22'd0);
    end

    // Next-state, input backpressure and output register loading.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        hold_d       = hold_q;
        hold_keep_d  = hold_keep_q;
        meta_valid_d = meta_valid_q;
        meta_mac_d   = meta_mac_q;
        meta_ip_d    = meta_ip_q;
        meta_port_d  = meta_port_q;
        meta_len_d   = meta_len_q;
        acc_d        = acc_q;
        drop_d       = drop_q;

        out_free  = !out_valid_q | udp_rx_axis_tready;
        meta_free = !meta_valid_q | udp_rx_meta_ready;

        if (out_valid_q && udp_rx_axis_tready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (meta_valid_q && udp_rx_meta_ready) begin
            meta_valid_d = 1'b0;
        end

        case (state_q)
            StIdle:   cmac_rx_axis_tready = out_free & meta_free;
            StFwd:    cmac_rx_axis_tready = out_free;
            StBypass: cmac_rx_axis_tready = out_free;
            StDrop:   cmac_rx_axis_tready = 1'b1;
            default:  cmac_rx_axis_tready = 1'b0;
        endcase
        cmac_rx_axis_tready = cmac_rx_axis_tready & rx_axis_aresetn;
        beat = cmac_rx_axis_tvalid & cmac_rx_axis_tready;

        case (state_q)
            StIdle: begin
                if (beat) begin
                    if (!rx_engine_enable) begin
                        drop_d  = sat_inc(drop_q);
                        state_d = cmac_rx_axis_tlast ? StIdle : StDrop;
                    end else if (rx_engine_bypass) begin
                        out_data_d  = cmac_rx_axis_tdata;
                        out_keep_d  = cmac_rx_axis_tkeep;
                        out_valid_d = 1'b1;
                        out_last_d  = cmac_rx_axis_tlast;
                        state_d     = cmac_rx_axis_tlast ? StIdle : StBypass;
                    end else if (!hdr_ok || (cmac_rx_axis_tlast && tail_empty)) begin
                        // Header mismatch or a UDP datagram with nothing to deliver.
                        drop_d  = sat_inc(drop_q);
                        state_d = cmac_rx_axis_tlast ? StIdle : StDrop;
                    end else begin
                        hold_d       = cmac_rx_axis_tdata[511:336];
                        hold_keep_d  = cmac_rx_axis_tkeep[63:42];
                        meta_valid_d = 1'b1;
                        meta_mac_d   = {in_b[6], in_b[7], in_b[8], in_b[9], in_b[10], in_b[11]};
                        meta_ip_d    = {in_b[26], in_b[27], in_b[28], in_b[29]};
                        meta_port_d  = {in_b[34], in_b[35]};
                        meta_len_d   = {in_b[38], in_b[39]} - 16'd8;
                        acc_d        = sat_inc(acc_q);
                        state_d      = cmac_rx_axis_tlast ? StTail : StFwd;
                    end
                end
            end
            StFwd: begin
                if (beat) begin
                    out_data_d  = {cmac_rx_axis_tdata[335:0], hold_q};
                    out_keep_d  = {cmac_rx_axis_tkeep[41:0], hold_keep_q};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    hold_d      = cmac_rx_axis_tdata[511:336];
                    hold_keep_d = cmac_rx_axis_tkeep[63:42];
                    if (cmac_rx_axis_tlast) begin
                        out_last_d = tail_empty;
                        state_d    = tail_empty ? StIdle : StTail;
                    end
                end
            end
            StTail: begin
                if (out_free) begin
                    out_data_d  = {336'd0, hold_q};
                    out_keep_d  = {42'd0, hold_keep_q};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            StBypass: begin
                if (beat) begin
                    out_data_d  = cmac_rx_axis_tdata;
                    out_keep_d  = cmac_rx_axis_tkeep;
                    out_valid_d = 1'b1;
                    out_last_d  = cmac_rx_axis_tlast;
                    if (cmac_rx_axis_tlast) state_d = StIdle;
                end
            end
            StDrop: begin
                if (beat && cmac_rx_axis_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            state_q      <= StIdle;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            hold_q       <= '0;
            hold_keep_q  <= '0;
            meta_valid_q <= 1'b0;
            meta_mac_q   <= '0;
            meta_ip_q    <= '0;
            meta_port_q  <= '0;
            meta_len_q   <= '0;
            acc_q        <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            hold_q       <= hold_d;
            hold_keep_q  <= hold_keep_d;
            meta_valid_q <= meta_valid_d;
            meta_mac_q   <= meta_mac_d;
            meta_ip_q    <= meta_ip_d;
            meta_port_q  <= meta_port_d;
            meta_len_q   <= meta_len_d;
            acc_q        <= acc_d;
            drop_q       <= drop_d;
        end
    end

    assign udp_rx_axis_tdata   = out_data_q;
    assign udp_rx_axis_tkeep   = out_keep_q;
    assign udp_rx_axis_tvalid  = out_valid_q;
    assign udp_rx_axis_tlast   = out_last_q;
    assign udp_rx_meta_valid   = meta_valid_q;
    assign udp_rx_meta_srcMac  = meta_mac_q;
    assign udp_rx_meta_srcIp   = meta_ip_q;
    assign udp_rx_meta_srcPort = meta_port_q;
    assign udp_rx_meta_length  = meta_len_q;
    assign stat_accepted       = acc_q;
    assign stat_dropped        = drop_q;

endmodule
